btn_debounce_pulser: RTL and testbench

- Conditions one raw push-button input into a debounced level plus single-cycle press/release pulses.
- Sits directly upstream of the threshold presets selector: o_btn_press drives that selector's preset-change input, so each physical press advances the preset exactly once.
- Optional auto-repeat emits periodic press pulses while the button is held, for fast preset cycling.
- Runs in the 20 MHz domain.

---
 rtl/btn_debounce_pulser.sv | 161 ++++++++++++++++
 tb/tb_btn_debounce_pulser.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_pulser.sv
// btn_debounce_pulser: conditions one raw push-button into a debounced level
// plus single-cycle press/release pulses, with optional auto-repeat presses
// while the button is held. Single 20 MHz clock domain.
module btn_debounce_pulser #(
    parameter int   parm_debounce_cycles      = 20000,
    parameter logic parm_repeat_enable        = 1'b0,
    parameter int   parm_repeat_delay_cycles  = 10000000,
    parameter int   parm_repeat_period_cycles = 4000000
) (
    input  logic i_clk_20mhz,
    input  logic i_rst_20mhz,
    input  logic i_btn_raw,
    output logic o_btn_deb,
    output logic o_btn_press,
    output logic o_btn_release
);

    localparam logic [23:0] DEB_N = 24'(parm_debounce_cycles);
    localparam logic [23:0] DLY_N = 24'(parm_repeat_delay_cycles);
    localparam logic [23:0] PER_N = 24'(parm_repeat_period_cycles);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic        btn_meta, s_btn_sync;
    logic [23:0] deb_cnt, deb_cnt_nxt;
    logic [23:0] rpt_cnt, rpt_cnt_nxt;
    logic        rpt_phase, rpt_phase_nxt;
    logic        deb_nxt, press_nxt, rel_nxt;
    logic [23:0] deb_inc, rpt_inc;
    logic        deb_done, rpt_hit;

    // Counters transition at equality, so they never reach their wrap point.
    assign deb_inc  = deb_cnt + 24'd1;
    assign rpt_inc  = rpt_cnt + 24'd1;
    assign deb_done = (deb_inc == DEB_N);
    // First repeat waits the long delay, later ones the shorter period.
    assign rpt_hit  = (rpt_inc == (rpt_phase ? PER_N : DLY_N));

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            btn_meta   <= 1'b0;
            s_btn_sync <= 1'b0;
        end else begin
            btn_meta   <= i_btn_raw;
            s_btn_sync <= btn_meta;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            state         <= ST_IDLE;
            deb_cnt       <= 24'd0;
            rpt_cnt       <= 24'd0;
            rpt_phase     <= 1'b0;
            o_btn_deb     <= 1'b0;
            o_btn_press   <= 1'b0;
            o_btn_release <= 1'b0;
        end else begin
            state         <= state_nxt;
            deb_cnt       <= deb_cnt_nxt;
            rpt_cnt       <= rpt_cnt_nxt;
            rpt_phase     <= rpt_phase_nxt;
            o_btn_deb     <= deb_nxt;
            o_btn_press   <= press_nxt;
            o_btn_release <= rel_nxt;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_nxt     = state;
        deb_cnt_nxt   = deb_cnt;
        rpt_cnt_nxt   = rpt_cnt;
        rpt_phase_nxt = rpt_phase;
        case (state)
            ST_IDLE: begin
                if (s_btn_sync) begin
                    state_nxt   = ST_PRESS_WAIT;
                    deb_cnt_nxt = 24'd1;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s_btn_sync) begin
                    state_nxt   = ST_IDLE;
                    deb_cnt_nxt = 24'd0;
                end else if (deb_done) begin
                    state_nxt     = ST_HELD;
                    deb_cnt_nxt   = 24'd0;
                    rpt_cnt_nxt   = 24'd0;
                    rpt_phase_nxt = 1'b0;
                end else begin
                    deb_cnt_nxt = deb_inc;
                end
            end
            ST_HELD: begin
                if (!s_btn_sync) begin
                    state_nxt   = ST_RELEASE_WAIT;
                    deb_cnt_nxt = 24'd1;
                end else if (parm_repeat_enable) begin
                    if (rpt_hit) begin
                        rpt_cnt_nxt   = 24'd0;
                        rpt_phase_nxt = 1'b1;
                    end else begin
                        rpt_cnt_nxt = rpt_inc;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                // Repeat counter and phase are kept so a release glitch
                // does not restart the repeat schedule.
                if (s_btn_sync) begin
                    state_nxt   = ST_HELD;
                    deb_cnt_nxt = 24'd0;
                end else if (deb_done) begin
                    state_nxt     = ST_IDLE;
                    deb_cnt_nxt   = 24'd0;
                    rpt_cnt_nxt   = 24'd0;
                    rpt_phase_nxt = 1'b0;
                end else begin
                    deb_cnt_nxt = deb_inc;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next output values; level changes only alongside a pulse.
    always_comb begin
        deb_nxt   = o_btn_deb;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        case (state)
            ST_PRESS_WAIT: begin
                if (s_btn_sync && deb_done) begin
                    deb_nxt   = 1'b1;
                    press_nxt = 1'b1;
                end
            end
            ST_HELD: begin
                if (s_btn_sync && parm_repeat_enable && rpt_hit)
                    press_nxt = 1'b1;
            end
            ST_RELEASE_WAIT: begin
                if (!s_btn_sync && deb_done) begin
                    deb_nxt = 1'b0;
                    rel_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_btn_debounce_pulser.sv
// Testbench: two instances (repeat off / repeat on) share the reset. Stimulus
// pushes expected pulses (kind, cycle, preset) into per-instance queues; a
// negedge monitor pops and compares whenever an instance emits a pulse.
module tb_btn_debounce_pulser;

    typedef struct {
        bit rel;
        int cyc;
        int preset;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic raw_a, raw_b;
    logic deb_a, press_a, rel_a;
    logic deb_b, press_b, rel_b;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   preset = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic prev_deb_a = 1'b0, prev_deb_b = 1'b0;
    logic prev_pul_a = 1'b0, prev_pul_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_debounce_pulser #(
        .parm_debounce_cycles(4), .parm_repeat_enable(1'b0),
        .parm_repeat_delay_cycles(20), .parm_repeat_period_cycles(8)
    ) dut (
        .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_btn_raw(raw_a),
        .o_btn_deb(deb_a), .o_btn_press(press_a), .o_btn_release(rel_a)
    );

    btn_debounce_pulser #(
        .parm_debounce_cycles(4), .parm_repeat_enable(1'b1),
        .parm_repeat_delay_cycles(20), .parm_repeat_period_cycles(8)
    ) dut_rpt (
        .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_btn_raw(raw_b),
        .o_btn_deb(deb_b), .o_btn_press(press_b), .o_btn_release(rel_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input bit r, input int c, input int p);
        exp_t e;
        e.rel = r; e.cyc = c; e.preset = p;
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic chk_direct(input string name, input logic [2:0] act, input logic [2:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Compare one emitted pulse against the head of that instance's queue.
    task automatic chk_pulse(input int d, input logic p, input logic r,
                             input logic deb, input logic prev_pul);
        exp_t e;
        bit   have;
        vectors++;
        have = 1'b0;
        if (d == 0 && qa.size() != 0) begin e = qa.pop_front(); have = 1'b1; end
        if (d == 1 && qb.size() != 0) begin e = qb.pop_front(); have = 1'b1; end
        if (p && d == 0) preset = (preset + 1) % 10;
        if (!have) begin
            miscompares++;
            $display("FAIL unexpected_pulse d%0d: press=%0b release=%0b at cycle %0d, expected none",
                     d, p, r, cyc);
        end else if ((p && r) || prev_pul || (e.rel != r) || (e.cyc != cyc)
                     || (deb != !r)) begin
            miscompares++;
            $display("FAIL pulse d%0d: got press=%0b release=%0b cycle=%0d deb=%0b prev_pulse=%0b, expected release=%0b cycle=%0d deb=%0b",
                     d, p, r, cyc, deb, prev_pul, e.rel, e.cyc, !e.rel);
        end else if (p && d == 0 && e.preset >= 0 && preset != e.preset) begin
            miscompares++;
            $display("FAIL preset_chain: got preset %0d, expected %0d at cycle %0d",
                     preset, e.preset, cyc);
        end
    endtask

    task automatic chk_level(input int d, input logic deb, input logic pul);
        vectors++;
        if (!pul) begin
            miscompares++;
            $display("FAIL deb_without_pulse d%0d: deb changed to %0b at cycle %0d, expected a pulse",
                     d, deb, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_deb_a <= 1'b0; prev_deb_b <= 1'b0;
            prev_pul_a <= 1'b0; prev_pul_b <= 1'b0;
        end else begin
            if (press_a || rel_a) chk_pulse(0, press_a, rel_a, deb_a, prev_pul_a);
            if (press_b || rel_b) chk_pulse(1, press_b, rel_b, deb_b, prev_pul_b);
            if (deb_a != prev_deb_a) chk_level(0, deb_a, press_a || rel_a);
            if (deb_b != prev_deb_b) chk_level(1, deb_b, press_b || rel_b);
            prev_deb_a <= deb_a; prev_deb_b <= deb_b;
            prev_pul_a <= press_a || rel_a;
            prev_pul_b <= press_b || rel_b;
        end
    end

    initial begin
        int a, r;
        rst = 1'b1; raw_a = 1'b0; raw_b = 1'b0;
        tick(3);
        chk_direct("reset_a", {deb_a, press_a, rel_a}, 3'b000);
        chk_direct("reset_b", {deb_b, press_b, rel_b}, 3'b000);
        rst = 1'b0;
        tick(3);

        // Clean press, repeat disabled: one pulse 6 cycles after the raw edge.
        raw_a = 1'b1; push(0, 1'b0, cyc + 6, -1);
        tick(30);
        chk_direct("clean_held_a", {deb_a, press_a, rel_a}, 3'b100);
        raw_a = 1'b0; push(0, 1'b1, cyc + 6, -1);
        tick(12);

        // Bounce: 1,1,1,0 never accumulates 4 stable samples.
        for (int i = 0; i < 40; i++) begin
            raw_a = (i % 4 != 3);
            tick(1);
        end
        chk_direct("bounce_a", {deb_a, press_a, rel_a}, 3'b000);
        raw_a = 1'b1; push(0, 1'b0, cyc + 6, -1);
        tick(15);

        // Release glitch: 0,0,1 then steady 0; release 6 after the final fall.
        raw_a = 1'b0; push(0, 1'b1, cyc + 9, -1);
        tick(2);
        raw_a = 1'b1;
        tick(1);
        raw_a = 1'b0;
        tick(15);
        chk_direct("after_release_a", {deb_a, press_a, rel_a}, 3'b000);

        // Auto-repeat: accept, +20, then every 8.
        raw_b = 1'b1; a = cyc + 6;
        push(1, 1'b0, a, -1);
        push(1, 1'b0, a + 20, -1);
        push(1, 1'b0, a + 28, -1);
        push(1, 1'b0, a + 36, -1);
        push(1, 1'b0, a + 44, -1);
        push(1, 1'b0, a + 52, -1);
        tick(61);
        raw_b = 1'b0; push(1, 1'b1, cyc + 6, -1);
        tick(15);

        // Preset chain: 11 presses step a mod-10 preset 1..9,0,1.
        preset = 0;
        for (int p = 1; p <= 11; p++) begin
            raw_a = 1'b1; push(0, 1'b0, cyc + 6, p % 10);
            tick(8);
            raw_a = 1'b0; push(0, 1'b1, cyc + 6, -1);
            tick(10);
        end

        // Reset mid-count on A (count=2) while B is held and debounced.
        raw_b = 1'b1; push(1, 1'b0, cyc + 6, -1);
        tick(10);
        raw_a = 1'b1;
        tick(4);
        rst = 1'b1;
        #1;
        chk_direct("midreset_a", {deb_a, press_a, rel_a}, 3'b000);
        chk_direct("midreset_b", {deb_b, press_b, rel_b}, 3'b000);
        tick(3);
        rst = 1'b0; r = cyc;
        push(0, 1'b0, r + 6, -1);
        push(1, 1'b0, r + 6, -1);
        tick(10);
        raw_a = 1'b0; raw_b = 1'b0;
        push(0, 1'b1, cyc + 6, -1);
        push(1, 1'b1, cyc + 6, -1);
        tick(20);

        vectors++;
        if (qa.size() != 0) begin
            miscompares++;
            $display("FAIL pending_a: %0d expected pulses never seen, expected 0", qa.size());
        end
        vectors++;
        if (qb.size() != 0) begin
            miscompares++;
            $display("FAIL pending_b: %0d expected pulses never seen, expected 0", qb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
